lane_stimulus_gen: RTL
======================

// Module: lane_stimulus_gen
// PURPOSE
//  - Upstream stimulus source for the 8-lane enable-gated capture-flop stage fed by the PLL-derived clocks.
//  - Drives per-lane data and enable patterns:
//    - PRBS data from a 16-bit LFSR.
//    - Enable mask: all-on or walking-one.
//  - Runs a fixed-length burst under a start/busy/done handshake; runs on one clock.
// PARAMETERS
//  - SEED      16'hACE1  LFSR seed; 16'h0000 is forced to 16'hACE1.
//  - LEN_W     8         Width of burst_len / beat counter.
//  - EN_MODE   0         0 = enable_o all ones during RUN; 1 = walking one.
//  - CHECK_LAT 2         LANE_CHECK_EN only: cycles from data_o to matching loop_i (1..7).
//  - ERR_W     16        LANE_CHECK_EN only: err_cnt width.
// PORTS
//  - clk        in   1      Single clock; all logic on posedge.
//  - rst        in   1      Asynchronous reset, active-high.
//  - start      in   1      Level-sampled burst request; honoured in IDLE only.
//  - burst_len  in   LEN_W  Number of beats; latched on accepted start.
//  - data_o     out  8      Per-lane stimulus data.
//  - enable_o   out  8      Per-lane capture enable.
//  - busy       out  1      High in RUN and DONE.
//  - done       out  1      One-cycle pulse in DONE.
//  - loop_i     in   8      LANE_CHECK_EN only: captured lanes looped back.
//  - err_cnt    out  ERR_W  LANE_CHECK_EN only: saturating mismatch count.
// BEHAVIOUR
//  - Reset (async assert, registered deassert effect): state=IDLE; data_o=0; enable_o=0; busy=0; done=0; lfsr=SEED; beat=0; err_cnt=0.
//  - All outputs are registered.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    - IDLE, start=1, burst_len!=0:
//      - Next state RUN. Latch len=burst_len, lfsr=SEED, beat=0.
//      - LANE_CHECK_EN: clear err_cnt.
//    - IDLE, start=1, burst_len==0: next state DONE; zero beats issued.
//    - RUN, each cycle is one beat k (k=0..len-1):
//      - data_o = lfsr[7:0], taken before advance; beat 0 = SEED[7:0].
//      - enable_o = 8'hFF (EN_MODE=0), or 8'h01 << (k mod 8) (EN_MODE=1).
//      - lfsr advances: Fibonacci, taps 16,14,13,11; shift left; feedback into bit 0.
//      - Beat k=len-1 -> next state DONE.
//    - DONE: data_o=0, enable_o=0, done=1 for exactly one cycle; next state IDLE.
//  - Output timing:
//    - data_o / enable_o for beat k are valid the cycle after RUN is entered plus k (1-cycle output register).
//    - busy rises the cycle after start is accepted; busy falls together with done.
//  - start while busy: ignored, not queued. start held high through DONE re-triggers from IDLE the next cycle.
//  - len = 2^LEN_W - 1 is the maximum burst; beat counter never wraps within a burst.
//  - rst mid-burst: immediate return to reset values; no done pulse.
// CONFIGURATION
//  - Macro LANE_CHECK_EN.
//  - Defined:
//    - Delay data_o and enable_o by CHECK_LAT cycles through a shift register.
//    - Each cycle, for each lane i with delayed enable[i]=1 and loop_i[i] != delayed data[i], count one mismatch.
//    - Up to 8 mismatches are added per cycle; err_cnt saturates at all ones.
//    - The compare window covers CHECK_LAT cycles past DONE so that trailing beats are checked.
//  - Undefined: loop_i and err_cnt ports are absent; no delay line exists; all other behaviour is identical.
// TESTING
//  - Reset value check:
//    - Stimulus: rst pulse mid-RUN.
//    - Response: next edge data_o=0, enable_o=0, busy=0, done=0.
//    - Stimulus: start after reset.
//    - Response: first beat data_o=8'hE1.
//  - Walking-one burst:
//    - Stimulus: EN_MODE=1, burst_len=10.
//    - Response: enable_o = 01,02,04,...,80,01,02; exactly 10 beats.
//    - Response: done pulses once, 1 cycle after the last beat; busy high for 11 cycles.
//  - Zero-length burst:
//    - Stimulus: burst_len=0, start.
//    - Response: no beat with enable_o!=0; done pulses 1 cycle after busy rises.
//  - Start while busy:
//    - Stimulus: start re-asserted during RUN with burst_len=5, then 3.
//    - Response: burst length stays 5; second request is ignored.
//  - LANE_CHECK_EN, ideal loopback:
//    - Stimulus: loop_i = data_o delayed 2, burst_len=255.
//    - Response: err_cnt=0.
//  - LANE_CHECK_EN, stuck lane:
//    - Stimulus: loop_i[3] forced 0, EN_MODE=1, burst_len=16.
//    - Response: err_cnt = count of beats with k mod 8 == 3 and data bit3 = 1 (golden LFSR model).

Source files
------------

// File: rtl/lane_stimulus_gen.sv
// rtl/lane_stimulus_gen.sv - 8-lane PRBS/enable burst stimulus source with start/busy/done handshake
// Optional loopback mismatch counter is built when LANE_CHECK_EN is defined.
module lane_stimulus_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          LEN_W     = 8,
  parameter int          EN_MODE   = 0,
  parameter int          CHECK_LAT = 2,
  parameter int          ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic [7:0]       data_o,
  output logic [7:0]       enable_o,
  output logic             busy,
  output logic             done
`ifdef LANE_CHECK_EN
  ,
  input  logic [7:0]       loop_i,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  logic [1:0]       state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             last_beat;
  logic             fb;

  assign accept    = (state_q == S_IDLE) && start;
  assign last_beat = (beat_q == (len_q - LEN_W'(1)));
  assign fb        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    data_d  = 8'h00;
    en_d    = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d   = burst_len;
          lfsr_d  = SEED_EFF;
          beat_d  = '0;
          state_d = (burst_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        data_d = lfsr_q[7:0];
        en_d   = (EN_MODE == 1) ? (8'h01 << beat_q[2:0]) : 8'hFF;
        lfsr_d = {lfsr_q[14:0], fb};
        beat_d = beat_q + LEN_W'(1);
        if (last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_q == S_DONE);
    // busy tracks the registered state, except a zero-length burst raises it
    // at once so that it still leads its done pulse by one cycle.
    busy_d = (state_q != S_IDLE) || (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      len_q   <= '0;
      beat_q  <= '0;
      data_q  <= 8'h00;
      en_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_o   = data_q;
  assign enable_o = en_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef LANE_CHECK_EN
  logic [7:0]       dly_data_q [CHECK_LAT];
  logic [7:0]       dly_en_q   [CHECK_LAT];
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       miss_vec;
  logic [3:0]       miss_num;
  logic [ERR_W:0]   err_sum;

  // Delay line re-aligns the driven pattern with the looped-back capture.
  always_comb begin
    miss_vec = (loop_i ^ dly_data_q[CHECK_LAT-1]) & dly_en_q[CHECK_LAT-1];
    miss_num = 4'd0;
    for (int i = 0; i < 8; i++) begin
      miss_num = miss_num + {3'b000, miss_vec[i]};
    end
    err_sum = {1'b0, err_q} + (ERR_W+1)'(miss_num);
    if (accept) begin
      err_d = '0;
    end else if (err_sum[ERR_W]) begin
      err_d = '1;
    end else begin
      err_d = err_sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < CHECK_LAT; j++) begin
        dly_data_q[j] <= 8'h00;
        dly_en_q[j]   <= 8'h00;
      end
      err_q <= '0;
    end else begin
      dly_data_q[0] <= data_q;
      dly_en_q[0]   <= en_q;
      for (int j = 1; j < CHECK_LAT; j++) begin
        dly_data_q[j] <= dly_data_q[j-1];
        dly_en_q[j]   <= dly_en_q[j-1];
      end
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule
